// File: rtl/pcs_receive_pkg.sv
// Shared constants, state encoding and code-group helpers for the PCS receive path.
// Pure definitions; no timing or flow control of its own.
package pcs_receive_pkg;

  // Both running-disparity columns of the delimiter code groups (abcdei_fghj)
  localparam logic [9:0] K28_5_RDN = 10'b001111_1010;
  localparam logic [9:0] K28_5_RDP = 10'b110000_0101;
  localparam logic [9:0] K27_7_RDN = 10'b110110_1000;
  localparam logic [9:0] K27_7_RDP = 10'b001001_0111;
  localparam logic [9:0] K29_7_RDN = 10'b101110_1000;
  localparam logic [9:0] K29_7_RDP = 10'b010001_0111;
  localparam logic [9:0] K23_7_RDN = 10'b111010_1000;
  localparam logic [9:0] K23_7_RDP = 10'b000101_0111;

  localparam logic [7:0] PREAMBLE_DEF = 8'h55;
  localparam logic [7:0] CARRIER_EXT  = 8'h0F;

  typedef enum logic [3:0] {
    LINK_FAILED   = 4'd0,
    WAIT_FOR_K    = 4'd1,
    RX_K          = 4'd2,
    IDLE_D        = 4'd3,
    START         = 4'd4,
    RECEIVE       = 4'd5,
    RX_DATA_ERROR = 4'd6,
    TRI           = 4'd7,
    TRR           = 4'd8
  } rx_state_t;

  function automatic logic match_code(input logic [9:0] code, input logic rd,
                                      input logic [9:0] rdn, input logic [9:0] rdp);
    return code == (rd ? rdp : rdn);
  endfunction

endpackage

// File: rtl/decoder_8b10b.sv
// Combinational 8b/10b decoder for one code group in the column chosen by rd_in.
// Zero latency; no flow control.
module decoder_8b10b
  import pcs_receive_pkg::*;
(
  input  logic [9:0] code,
  input  logic       rd_in,
  output logic [7:0] octet,
  output logic       is_k,
  output logic       valid,
  output logic       rd_out
);

  logic [5:0] c6;
  logic [3:0] c4;
  logic [9:0] k28c;
  logic [2:0] ones6;
  logic [2:0] ones4;
  logic [3:0] ones10;
  logic [4:0] x;
  logic [2:0] y;
  logic [2:0] k28y;
  logic       ok6, ok4, col6, col4, rd_mid, p7, a7, a7_ok, kx7, k28_ok, d_ok, kx7_ok;

  always_comb begin
    c6     = code[9:4];
    c4     = code[3:0];
    ones6  = 3'($countones(c6));
    ones4  = 3'($countones(c4));
    ones10 = 4'($countones(code));

    ok6 = 1'b1;
    x   = 5'd0;
    case (c6)
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110:            x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      default:              ok6 = 1'b0;
    endcase

    // Unbalanced sub-blocks only appear in the column they flip away from
    if (ones6 == 3'd3)
      col6 = !((c6 == 6'b111000 && rd_in) || (c6 == 6'b000111 && !rd_in));
    else if (ones6 == 3'd4)
      col6 = !rd_in;
    else
      col6 = (ones6 == 3'd2) && rd_in;
    rd_mid = (ones6 == 3'd3) ? rd_in : (ones6 == 3'd4);

    ok4 = 1'b1;
    y   = 3'd0;
    p7  = 1'b0;
    a7  = 1'b0;
    case (c4)
      4'b1011, 4'b0100: y = 3'd0;
      4'b1001:          y = 3'd1;
      4'b0101:          y = 3'd2;
      4'b1100, 4'b0011: y = 3'd3;
      4'b1101, 4'b0010: y = 3'd4;
      4'b1010:          y = 3'd5;
      4'b0110:          y = 3'd6;
      4'b1110, 4'b0001: begin y = 3'd7; p7 = 1'b1; end
      4'b0111, 4'b1000: begin y = 3'd7; a7 = 1'b1; end
      default:          ok4 = 1'b0;
    endcase

    if (ones4 == 3'd2)
      col4 = !((c4 == 4'b1100 && rd_mid) || (c4 == 4'b0011 && !rd_mid));
    else if (ones4 == 3'd3)
      col4 = !rd_mid;
    else
      col4 = (ones4 == 3'd1) && rd_mid;

    // Alternate D.x.7 form is mandatory exactly where primary would make a run of five
    a7_ok = (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
            ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    kx7   = (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30);

    d_ok   = ok6 && col6 && ok4 && col4 && (p7 ? !a7_ok : (a7 ? a7_ok : 1'b1));
    kx7_ok = ok6 && col6 && ok4 && col4 && a7 && kx7;

    // K28.y in RD+ is the bitwise complement of its RD- form
    k28c   = rd_in ? ~code : code;
    k28_ok = (k28c[9:4] == 6'b001111);
    k28y   = 3'd0;
    case (k28c[3:0])
      4'b0100: k28y = 3'd0;
      4'b1001: k28y = 3'd1;
      4'b0101: k28y = 3'd2;
      4'b0011: k28y = 3'd3;
      4'b0010: k28y = 3'd4;
      4'b1010: k28y = 3'd5;
      4'b0110: k28y = 3'd6;
      4'b1000: k28y = 3'd7;
      default: k28_ok = 1'b0;
    endcase

    valid = k28_ok || kx7_ok || d_ok;
    is_k  = k28_ok || kx7_ok;
    octet = k28_ok ? {k28y, 5'd28} : {y, x};

    if (valid)
      rd_out = (ones4 == 3'd2) ? rd_mid : (ones4 > 3'd2);
    else if (ones10 > 4'd5)
      rd_out = 1'b1;
    else if (ones10 < 4'd5)
      rd_out = 1'b0;
    else
      rd_out = rd_in;
  end

endmodule

// File: rtl/pcs_receive.sv
// PCS receive state machine: decoded code groups in, GMII-style RXD/RX_DV/RX_ER out.
// One-cycle registered latency; no backpressure, one code group consumed per Clk.
module pcs_receive
  import pcs_receive_pkg::*;
#(
  parameter logic [7:0] PREAMBLE = PREAMBLE_DEF
) (
  input  logic        Clk,
  input  logic        mr_main_reset,
  input  logic        code_sync_status,
  input  logic [10:0] SUDI,
  output logic [7:0]  RXD,
  output logic        RX_DV,
  output logic        RX_ER,
  output logic        receiving,
  output logic        rx_disparity
);

  rx_state_t  state;
  logic [9:0] code;
  logic       rx_even;
  logic [7:0] dec_octet;
  logic       dec_is_k, dec_valid, dec_rd;
  logic       is_d, is_kc, is_s, is_t, is_r;

  assign code    = SUDI[9:0];
  assign rx_even = SUDI[10];

  decoder_8b10b u_dec (
    .code   (code),
    .rd_in  (rx_disparity),
    .octet  (dec_octet),
    .is_k   (dec_is_k),
    .valid  (dec_valid),
    .rd_out (dec_rd)
  );

  assign is_d  = dec_valid && !dec_is_k;
  assign is_kc = match_code(code, rx_disparity, K28_5_RDN, K28_5_RDP);
  assign is_s  = match_code(code, rx_disparity, K27_7_RDN, K27_7_RDP);
  assign is_t  = match_code(code, rx_disparity, K29_7_RDN, K29_7_RDP);
  assign is_r  = match_code(code, rx_disparity, K23_7_RDN, K23_7_RDP);

  always_ff @(posedge Clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state        <= LINK_FAILED;
      RXD          <= 8'h00;
      RX_DV        <= 1'b0;
      RX_ER        <= 1'b0;
      receiving    <= 1'b0;
      rx_disparity <= 1'b0;
    end else if (!code_sync_status) begin
      // Losing sync mid-frame is flagged once, then the link sits quiet
      state     <= LINK_FAILED;
      RXD       <= 8'h00;
      RX_DV     <= 1'b0;
      RX_ER     <= receiving;
      receiving <= 1'b0;
    end else begin
      rx_disparity <= dec_rd;
      RXD          <= 8'h00;
      RX_DV        <= 1'b0;
      RX_ER        <= 1'b0;
      case (state)
        LINK_FAILED: state <= WAIT_FOR_K;
        WAIT_FOR_K:  if (is_kc && rx_even) state <= RX_K;
        RX_K:        state <= is_d ? IDLE_D : WAIT_FOR_K;
        IDLE_D: begin
          if (is_kc && rx_even) begin
            state <= RX_K;
          end else if (is_s && rx_even) begin
            state     <= START;
            RX_DV     <= 1'b1;
            RXD       <= PREAMBLE;
            receiving <= 1'b1;
          end else begin
            state <= WAIT_FOR_K;
          end
        end
        START, RECEIVE, RX_DATA_ERROR: begin
          if (is_d) begin
            state <= RECEIVE;
            RXD   <= dec_octet;
            RX_DV <= 1'b1;
          end else if (is_t) begin
            state <= TRI;
          end else if (is_kc) begin
            state     <= RX_K;
            RX_ER     <= 1'b1;
            receiving <= 1'b0;
          end else begin
            state <= RX_DATA_ERROR;
            RX_DV <= 1'b1;
            RX_ER <= 1'b1;
          end
        end
        TRI: begin
          receiving <= 1'b0;
          if (is_r) begin
            state <= TRR;
          end else begin
            state <= WAIT_FOR_K;
            RX_ER <= 1'b1;
          end
        end
        TRR: begin
          if (is_r) begin
            RX_ER <= 1'b1;
            RXD   <= CARRIER_EXT;
          end else if (is_kc && rx_even) begin
            state <= RX_K;
          end else begin
            state <= WAIT_FOR_K;
          end
        end
        default: state <= LINK_FAILED;
      endcase
    end
  end

endmodule
